// File: rtl/mantissa_divider_seq_if.sv
// Handshake and result bundle for the sequential mantissa divider.
interface mantissa_divider_seq_if #(
  parameter int unsigned WIDTH = 11
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             div_by_zero;

  modport master (
    output start, A, B,
    input  ready, busy, done, Q, R, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output ready, busy, done, Q, R, div_by_zero
  );
endinterface

// File: rtl/mantissa_divider_seq.sv
// Iterative restoring divider, 11-bit unsigned, one quotient bit per clock.
// Trial subtractions run on the 11-bit carry-lookahead adder as A + ~B + 1.

// 11-bit carry-lookahead adder with fully expanded carry terms.
module mantissa_cla_adder11 (
  input  logic [10:0] a,
  input  logic [10:0] b,
  input  logic        cin,
  output logic [10:0] sum,
  output logic        cout
);
  logic [10:0] g;
  logic [10:0] p;
  logic [11:0] c;
  logic        term;

  // Generate/propagate and flattened lookahead carries.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    term = 1'b0;
    c[0] = cin;
    for (int unsigned i = 1; i <= 11; i++) begin
      term = cin;
      for (int unsigned k = 0; k < i; k++) begin
        term = term & p[k];
      end
      c[i] = term;
      for (int unsigned j = 0; j < i; j++) begin
        term = g[j];
        for (int unsigned k = j + 1; k < i; k++) begin
          term = term & p[k];
        end
        c[i] = c[i] | term;
      end
    end
    sum  = p ^ c[10:0];
    cout = c[11];
  end
endmodule

// Divider top: IDLE -> RUN (WIDTH iterations) -> DONE -> IDLE.
module mantissa_divider_seq #(
  parameter int unsigned WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  mantissa_divider_seq_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] qs_q, qs_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;

  logic             m;
  logic [WIDTH-1:0] pt;
  logic [WIDTH-1:0] diff;
  logic             cout;
  logic             succ;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] qs_next;

  // Shift {P, QS} left by one and form the trial value.
  always_comb begin
    m  = p_q[WIDTH-1];
    pt = {p_q[WIDTH-2:0], qs_q[WIDTH-1]};
  end

  mantissa_cla_adder11 u_adder (
    .a    (pt),
    .b    (~div_q),
    .cin  (1'b1),
    .sum  (diff),
    .cout (cout)
  );

  // Next-state and datapath next values; every target defaults to hold.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    qs_d    = qs_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    // The bit shifted out of P means the trial value already exceeds B.
    succ    = m | cout;
    p_next  = succ ? diff : pt;
    qs_next = {qs_q[WIDTH-2:0], succ};

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          div_d = bus.B;
          qs_d  = bus.A;
          p_d   = '0;
          cnt_d = CNT_W'(WIDTH - 1);
          if (bus.B == '0) begin
            q_d     = '1;
            r_d     = bus.A;
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            q_d     = '0;
            r_d     = '0;
            dz_d    = 1'b0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        p_d  = p_next;
        qs_d = qs_next;
        if (cnt_q == '0) begin
          q_d     = qs_next;
          r_d     = p_next;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      qs_q    <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      qs_q    <= qs_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.ready       = (state_q == ST_IDLE);
  assign bus.busy        = (state_q == ST_RUN);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.Q           = q_q;
  assign bus.R           = r_q;
  assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_mantissa_divider_seq.sv
// Scoreboard bench for mantissa_divider_seq.
module tb_mantissa_divider_seq;
  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  typedef struct {
    int q;
    int r;
    int dz;
    int cyc;
  } exp_t;

  exp_t sb[$];

  mantissa_divider_seq_if #(.WIDTH(11)) bus ();

  mantissa_divider_seq #(.WIDTH(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("Q",           int'(bus.Q), e.q);
        chk("R",           int'(bus.R), e.r);
        chk("div_by_zero", int'(bus.div_by_zero), e.dz);
        chk("done_cycle",  cyc, e.cyc);
      end
    end
  end

  // Accept one operation: expected values are hand-supplied.
  task automatic issue(input int a, input int b, input int eq, input int er, input int edz);
    int   n;
    exp_t e;
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 0, 1);
    bus.A     = a[10:0];
    bus.B     = b[10:0];
    bus.start = 1'b1;
    e.q   = eq;
    e.r   = er;
    e.dz  = edz;
    e.cyc = cyc + ((b == 0) ? 1 : 12);
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Pulse start for one cycle without expecting acceptance.
  task automatic poke(input int a, input int b);
    bus.A     = a[10:0];
    bus.B     = b[10:0];
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    int a, b, n;
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_busy",  int'(bus.busy), 0);
    chk("rst_done",  int'(bus.done), 0);
    chk("rst_Q",     int'(bus.Q), 0);
    chk("rst_R",     int'(bus.R), 0);
    chk("rst_dz",    int'(bus.div_by_zero), 0);
    rst = 1'b0;
    @(negedge clk);

    // 100/7 with per-cycle handshake checks (now in cycle 1 after issue).
    issue(100, 7, 14, 2, 0);
    for (int k = 1; k <= 13; k++) begin
      chk($sformatf("busy_c%0d", k),  int'(bus.busy), (k <= 11) ? 1 : 0);
      chk($sformatf("ready_c%0d", k), int'(bus.ready), (k == 13) ? 1 : 0);
      if (k < 13) @(negedge clk);
    end

    issue(2047, 1, 2047, 0, 0);
    issue(2047, 2047, 1, 0, 0);
    issue(5, 9, 0, 5, 0);
    issue(1024, 3, 341, 1, 0);

    // Divide by zero, then a normal op that clears the flag.
    issue(1234, 0, 2047, 1234, 1);
    @(negedge clk);
    chk("dz_ready_c2", int'(bus.ready), 1);
    issue(9, 3, 3, 0, 0);

    // Starts while busy are ignored; re-assert in cycle 13 is accepted.
    issue(100, 7, 14, 2, 0);
    repeat (2) @(negedge clk);
    poke(50, 5);
    repeat (8) @(negedge clk);
    poke(50, 5);
    chk("ready_c13", int'(bus.ready), 1);
    issue(50, 5, 10, 0, 0);

    // Reset mid-operation discards the op.
    while (bus.ready !== 1'b1) @(negedge clk);
    bus.A = 11'd2000; bus.B = 11'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", int'(bus.ready), 1);
    chk("mid_rst_busy",  int'(bus.busy), 0);
    chk("mid_rst_Q",     int'(bus.Q), 0);
    chk("mid_rst_R",     int'(bus.R), 0);
    repeat (2) @(negedge clk);
    issue(2000, 3, 666, 2, 0);

    // Random sweep, expectations from integer division.
    for (int i = 0; i < 200; i++) begin
      a = int'($urandom_range(0, 2047));
      b = int'($urandom_range(1, 2047));
      issue(a, b, a / b, a % b, 0);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
